// File: rtl/synth_wrapper.sv
// synth_wrapper: 4-bit ALU with one registered output stage.
// Arithmetic, logic and shift ops; carry holds carry/borrow/shift-out.
package synth_wrapper_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHR = 3'b110,
    OP_SHL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic       carry;
    logic [3:0] result;
  } alu_res_t;

endpackage

module synth_wrapper
  import synth_wrapper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       carry
);

  alu_op_e    op_e;
  alu_res_t   nxt;
  alu_res_t   q;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [4:0] shr_ext;
  logic [4:0] shl_ext;

  assign op_e = alu_op_e'(op);

  // Extra bit catches the carry/borrow out of the 4-bit lane.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Guard bit below a collects the last bit shifted out on SHR;
  // for b=0 it stays 0 and for b>=5 everything drops out.
  assign shr_ext = {a, 1'b0} >> b;

  // Guard bit above a collects the last bit shifted out on SHL.
  assign shl_ext = {1'b0, a} << b;

  // Operation select: combinational result and flag.
  always_comb begin
    nxt = '0;
    unique case (op_e)
      OP_ADD: nxt = sum;
      OP_SUB: nxt = diff;
      OP_AND: nxt.result = a & b;
      OP_OR:  nxt.result = a | b;
      OP_XOR: nxt.result = a ^ b;
      OP_NOT: nxt.result = ~a;
      OP_SHR: begin
        nxt.result = shr_ext[4:1];
        nxt.carry  = shr_ext[0];
      end
      OP_SHL: begin
        nxt.result = shl_ext[3:0];
        nxt.carry  = shl_ext[4];
      end
      default: nxt = '0;
    endcase
  end

  // Single output register; reset clears any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign result = q.result;
  assign carry  = q.carry;

endmodule

// File: tb/tb_synth_wrapper.sv
// tb_synth_wrapper: scoreboard bench for synth_wrapper.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_synth_wrapper;

  logic       clk;
  logic       rst_n;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] result;
  logic       carry;

  typedef struct {
    logic [3:0] res;
    logic       c;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  bit   have_last;
  int   n_checks;
  int   n_fail;

  synth_wrapper dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [3:0] got_r, input logic got_c,
                       input logic [3:0] exp_r, input logic exp_c);
    n_checks++;
    if (got_r !== exp_r || got_c !== exp_c) begin
      n_fail++;
      $display("FAIL %s: got result=%b carry=%b, want result=%b carry=%b",
               name, got_r, got_c, exp_r, exp_c);
    end
  endtask

  // Independent golden model written from the operation table.
  function automatic exp_t model(input logic [2:0] o,
                                 input logic [3:0] x,
                                 input logic [3:0] y);
    exp_t e;
    int   s;
    e.res = 4'h0;
    e.c   = 1'b0;
    e.name = "";
    case (o)
      3'd0: begin
        s = int'(x) + int'(y);
        e.res = 4'(s % 16);
        e.c = (s >= 16);
      end
      3'd1: begin
        s = int'(x) - int'(y) + 16;
        e.res = 4'(s % 16);
        e.c = (x < y);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~x;
      3'd6: begin
        e.res = (y >= 4) ? 4'h0 : (x >> y);
        if (y >= 1 && y <= 4) e.c = x[y - 1];
      end
      default: begin
        e.res = (y >= 4) ? 4'h0 : 4'(x << y);
        if (y >= 1 && y <= 4) e.c = x[4 - y];
      end
    endcase
    return e;
  endfunction

  task automatic apply(input logic [2:0] o, input logic [3:0] x,
                       input logic [3:0] y, input logic [3:0] er,
                       input logic ec, input string name);
    exp_t e;
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    e.res = er;
    e.c   = ec;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge compare against the oldest expectation,
  // then confirm the value holds until the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        last = exp_q.pop_front();
        have_last = 1'b1;
        check(last.name, result, carry, last.res, last.c);
      end else begin
        have_last = 1'b0;
      end
      @(negedge clk);
      #2;
      if (rst_n && have_last)
        check({last.name, "_hold"}, result, carry, last.res, last.c);
    end
  end

  initial begin
    exp_t e;
    int   budget;
    n_checks  = 0;
    n_fail    = 0;
    have_last = 1'b0;
    rst_n = 1'b0;
    op = 3'b000;
    a  = 4'hF;
    b  = 4'hF;
    #1;
    check("reset_pre_edge", result, carry, 4'h0, 1'b0);
    #6;
    check("reset_edge1", result, carry, 4'h0, 1'b0);
    #10;
    check("reset_edge2", result, carry, 4'h0, 1'b0);
    #3;
    rst_n = 1'b1;

    apply(3'b000, 4'd9, 4'd8, 4'd1, 1'b1, "add_9_8");
    apply(3'b000, 4'd3, 4'd4, 4'd7, 1'b0, "add_3_4");
    apply(3'b001, 4'd3, 4'd5, 4'd14, 1'b1, "sub_3_5");
    apply(3'b001, 4'd5, 4'd3, 4'd2, 1'b0, "sub_5_3");
    apply(3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, "and");
    apply(3'b011, 4'b1100, 4'b1010, 4'b1110, 1'b0, "or");
    apply(3'b100, 4'b1100, 4'b1010, 4'b0110, 1'b0, "xor");
    apply(3'b101, 4'b1100, 4'b1010, 4'b0011, 1'b0, "not");
    apply(3'b110, 4'b1011, 4'd1, 4'b0101, 1'b1, "shr_1");
    apply(3'b111, 4'b1011, 4'd2, 4'b1100, 1'b0, "shl_2");
    apply(3'b111, 4'b1011, 4'd4, 4'b0000, 1'b1, "shl_4");
    apply(3'b110, 4'b1011, 4'd0, 4'b1011, 1'b0, "shr_0");
    apply(3'b110, 4'b1011, 4'd9, 4'b0000, 1'b0, "shr_9");
    apply(3'b110, 4'b1011, 4'd4, 4'b0000, 1'b1, "shr_4");
    apply(3'b111, 4'b1011, 4'd0, 4'b1011, 1'b0, "shl_0");

    for (int i = 0; i < 16; i++) begin
      logic [2:0] o;
      logic [3:0] x;
      logic [3:0] y;
      o = 3'(i % 8);
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      e = model(o, x, y);
      apply(o, x, y, e.res, e.c, $sformatf("sweep%0d", i));
      if (i == 12) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", result, carry, 4'h0, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_hold", result, carry, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_wrapper.md
SYNTH_WRAPPER -- requirements
Module: synth_wrapper

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 op  input  3  SHALL select the operation.
REQ-005 a  input  4  SHALL be operand A, unsigned.
REQ-006 b  input  4  SHALL be operand B, unsigned; it is also the shift amount.
REQ-007 result  output  4  SHALL be the registered operation result.
REQ-008 carry  output  1  SHALL be the registered carry, borrow or shift-out flag.

Function
REQ-009 Outputs SHALL be registered, with latency 1: inputs sampled at rising edge N appear on result/carry immediately after edge N and hold until edge N+1.
REQ-010 Operation logic SHALL be combinational, feeding a single output register stage, with no other state.
REQ-011 op=000 (ADD): result = (a+b)[3:0]; carry = bit 4 of the 5-bit sum.
REQ-012 op=001 (SUB): result = (a-b) mod 16; carry = 1 when a<b (borrow), else 0.
REQ-013 op=010 (AND): result = a&b; carry = 0.
REQ-014 op=011 (OR): result = a|b; carry = 0.
REQ-015 op=100 (XOR): result = a^b; carry = 0.
REQ-016 op=101 (NOT): result = ~a; b ignored; carry = 0.
REQ-017 op=110 (SHR): logical right shift, zero fill: result = a>>b; carry = a[b-1] for 1<=b<=4, else 0.
REQ-018 op=111 (SHL): logical left shift, zero fill: result = (a<<b)[3:0]; carry = a[4-b] for 1<=b<=4, else 0.
REQ-019 Shift by b=0 SHALL give result=a and carry=0; shift by b>=4 SHALL give result=0.
REQ-020 All 8 op codes are defined, so there SHALL be no illegal opcode; X-free inputs SHALL give X-free outputs.
REQ-021 Changes to a, b or op between clock edges SHALL NOT affect outputs until the next rising edge.

Reset
REQ-022 When rst_n=0, result SHALL become 4'h0 and carry 0 immediately, without waiting for clk.
REQ-023 While rst_n=0, outputs SHALL hold zero regardless of clock and inputs.
REQ-024 After rst_n rises, the first rising edge SHALL load the registers from the current inputs.
REQ-025 Asserting reset mid-operation SHALL discard any pending result; no recovery state exists.

Verification
REQ-026 Reset: rst_n=0 at t=0 for 20 ns while clocking with a=4'hF, b=4'hF, op=000 -> result=0, carry=0 throughout, and also before the first clock edge.
REQ-027 ADD with a=9, b=8, op=000 -> one cycle later result=1, carry=1; a=3, b=4 -> result=7, carry=0.
REQ-028 SUB with a=3, b=5, op=001 -> result=14, carry=1; a=5, b=3 -> result=2, carry=0.
REQ-029 Logic with a=4'b1100, b=4'b1010:
- AND -> 1000
- OR -> 1110
- XOR -> 0110
- NOT -> 0011
- carry=0 for all four.
REQ-030 Shifts with a=4'b1011:
- SHR b=1 -> 0101, carry=1
- SHL b=2 -> 1100, carry=0
- SHL b=4 -> 0000, carry=1
- SHR b=0 -> 1011, carry=0
- SHR b=9 -> 0000, carry=0
REQ-031 Back-to-back op sweep 000..111 with random a, b, changing every 10 ns (clock period 10 ns): each cycle's outputs match the golden model for the inputs of the previous edge; then assert rst_n=0 mid-sweep -> outputs clear asynchronously.
